// File: rtl/sw_debounce.sv
// Switch-bus conditioner: 2-flop synchroniser, shared sample tick, per-bit
// consecutive-sample filter, registered change strobe. Define SW_DEBOUNCE_EDGE_EN for rise_o/fall_o.
module sw_debounce_lane #(
  parameter int STABLE_CNT = 4,
  parameter int CW         = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic tick,
  input  logic sample,
  output logic level,
  output logic flip
);
  logic [CW-1:0] cnt;

  always_comb flip = tick && (sample != level) && (cnt == CW'(STABLE_CNT-1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (tick) begin
      // a matching sample discards any progress, so only a clean run flips
      if (sample == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module sw_debounce #(
  parameter int WIDTH      = 10,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             changed_o
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`endif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  logic [WIDTH-1:0] sync1, sw_sync, flip;
  logic [PW-1:0]    pre;
  logic             tick;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1   <= '0;
      sw_sync <= '0;
    end else begin
      sync1   <= sw_i;
      sw_sync <= sync1;
    end
  end

  always_comb tick = (pre == PW'(TICK_DIV-1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    sw_debounce_lane #(.STABLE_CNT(STABLE_CNT), .CW(CW)) u_lane (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .tick   (tick),
      .sample (sw_sync[k]),
      .level  (sw_o[k]),
      .flip   (flip[k])
    );
  end

  // strobes are built from the flip decision so they land with the sw_o update
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) changed_o <= 1'b0;
    else         changed_o <= |flip;
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      rise_o <= flip & ~sw_o;
      fall_o <= flip & sw_o;
    end
  end
`endif
endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input-conditioning stage between the board slide switches and the 7-segment switch decoder. It synchronises the asynchronous switch bus into the clock domain, filters contact bounce per bit using a shared sample tick, and presents a clean, registered switch bus to the decoder's `sw_i`. It also emits a single-cycle change strobe for downstream sequential logic.

## Interface
- `WIDTH`, 10: number of switch bits.
- `TICK_DIV`, 50000: sample-tick period in `clk_i` cycles (1 ms at 50 MHz); legal range ≥ 2.
- `STABLE_CNT`, 4: consecutive differing samples required before an output bit flips; legal range ≥ 1.
- `clk_i` input 1: single clock.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `sw_i` input WIDTH: raw switch levels, asynchronous to `clk_i`.
- `sw_o` output WIDTH: debounced switch levels; feeds the decoder's `sw_i`.
- `changed_o` output 1: one-cycle strobe, high in the cycle `sw_o` takes a new value.
- `rise_o` output WIDTH: present only with `SW_DEBOUNCE_EDGE_EN`.
- `fall_o` output WIDTH: present only with `SW_DEBOUNCE_EDGE_EN`.

## Operation
- **Synchroniser.** Two flops per bit form `sw_sync`. Both reset to 0.
- **Prescaler.**
  - Counter runs 0..TICK_DIV-1 and resets to 0.
  - `tick` is high for one cycle when counter == TICK_DIV-1.
  - The counter wraps to 0 on the same edge.
- **Per-bit filter.**
  - Each bit has a counter `cnt_k` of width max(1, clog2(STABLE_CNT)), reset 0.
  - The filter acts only on `tick` cycles:
    - If `sw_sync[k]` == `sw_o[k]`: `cnt_k` ← 0.
    - Else if `cnt_k` == STABLE_CNT-1: `sw_o[k]` ← `sw_sync[k]` and `cnt_k` ← 0.
    - Else: `cnt_k` ← `cnt_k`+1.
  - With STABLE_CNT=1, a bit flips on the first differing tick.
  - Outside tick cycles, `cnt_k` and `sw_o` hold.
- **Bounce rejection.** Any tick where the sample equals `sw_o[k]` clears that bit's progress. An output flip therefore requires STABLE_CNT consecutive differing ticks.
- **Change strobe.**
  - `changed_o` is registered and is high exactly in the cycle where any `sw_o` bit differs from its previous value.
  - Several bits flipping on the same tick produce one strobe.
- **Reset.**
  - Reset clears, immediately and at any time (including mid-count): `sw_o`=0, `changed_o`=0, all `cnt_k`=0, prescaler=0, sync flops=0.
  - Reset never produces a strobe.
  - After release, switches that are already high re-debounce from zero. They produce a normal `changed_o` strobe.

## Timing
- **Reset values.** `sw_o`=0, `changed_o`=0, `rise_o`=0, `fall_o`=0.
- **Synchroniser latency.** 2 cycles from `sw_i` to `sw_sync`.
- **Step latency.**
  - Measured from the `sw_i` edge to the first cycle with the new `sw_o` value, for a clean step held long enough.
  - Minimum: (STABLE_CNT-1)·TICK_DIV + 3 cycles.
  - Maximum: STABLE_CNT·TICK_DIV + 2 cycles.
- **Strobe alignment.** `changed_o`, `rise_o` and `fall_o` are coincident with the `sw_o` update cycle. Each is exactly 1 cycle wide.
- **Minimum strobe spacing.** TICK_DIV cycles, because updates occur only on ticks.
- **Decoder path.** `sw_o` is glitch-free because it is a flop output. The decoder's combinational path adds no cycles.

## Configuration
- `SW_DEBOUNCE_EDGE_EN` defined:
  - `rise_o[k]` pulses for 1 cycle when `sw_o[k]` goes 0→1.
  - `fall_o[k]` pulses for 1 cycle when `sw_o[k]` goes 1→0.
  - Both are registered and reset to 0.
- `SW_DEBOUNCE_EDGE_EN` undefined:
  - `rise_o` and `fall_o` ports and their logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use TICK_DIV=4 and STABLE_CNT=3.
1. Reset: `rstn_i`=0 with `sw_i`=10'h3FF → `sw_o`=10'h000 and `changed_o`=0 throughout reset. After release, `sw_o`=10'h3FF within 11–14 cycles, with exactly one `changed_o` pulse.
2. Clean step: `sw_i` 10'h000→10'h2A5, held → `sw_o`=10'h2A5 11–14 cycles after the edge. `changed_o` is high for 1 cycle, coincident with the update. No intermediate `sw_o` values appear.
3. Bounce: `sw_i[0]` high for 6 cycles, then low → `sw_o` stays 10'h000 and `changed_o` never asserts.
4. Simultaneous: from 10'h000, `sw_i[9]` and `sw_i[0]` rise in the same cycle → `sw_o`=10'h201 in a single update cycle, with one `changed_o` pulse.
5. Reset mid-count: `sw_i` 10'h000→10'h010, `rstn_i` pulsed low after 2 differing ticks → `sw_o`=10'h000 immediately. After release, the update still takes a full 11–14 cycles.
6. With `SW_DEBOUNCE_EDGE_EN`: `sw_i[3]` 0→1, held 20 cycles, then 1→0 → `rise_o`=10'h008 for 1 cycle, later `fall_o`=10'h008 for 1 cycle. Each coincides with `changed_o`.
